two_digit_display_driver: RTL and testbench

Reads the 8-bit two-digit counter value (0–99) and drives a two-digit, common-anode, multiplexed seven-segment display. A sequential shift-add-3 (double-dabble) FSM converts the binary value to two BCD digits. A refresh divider alternates the two anodes. The block sits between the counter and the board's segment/anode pins, and is the display-side consumer of the counter output.

---
 rtl/two_digit_display_if.sv | 27 ++
 rtl/two_digit_display_driver.sv | 186 ++++++++++++++++++
 tb/tb_two_digit_display_driver.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/two_digit_display_if.sv
// Bundle between the counter side and the two-digit display driver.
// Handshake: there is no valid/ready pair. `value` and `blank` are levels
// sampled on every rising clk edge. The driver starts a conversion by itself
// whenever `value` differs from the last committed value. `busy` is high while
// a conversion runs, and the committed `bcd_*`/`ovf` outputs change only on the
// edge where `busy` falls. `state` is the driver's FSM state, exposed for debug.
interface two_digit_display_if;
    logic [7:0] value;
    logic       blank;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       ovf;
    logic       busy;
    logic       state;

    modport master (
        output value, blank,
        input  seg, an, bcd_tens, bcd_ones, ovf, busy, state
    );

    modport slave (
        input  value, blank,
        output seg, an, bcd_tens, bcd_ones, ovf, busy, state
    );
endinterface

// File: rtl/two_digit_display_driver.sv
// Two-digit multiplexed common-anode seven-segment driver. A shift-add-3 FSM
// converts the binary count into BCD one bit per cycle. A refresh divider
// alternates the two anodes, and seg/an come from a single output register.
module two_digit_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    two_digit_display_if.slave dd
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    localparam int         DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_OFF;
        endcase
    endfunction

    logic [0:0]       state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       cap_q, cap_d;
    logic [3:0]       tens_s_q, tens_s_d;
    logic [3:0]       ones_s_q, ones_s_d;
    logic [2:0]       iter_q, iter_d;
    logic [7:0]       last_q, last_d;
    logic             have_q, have_d;
    logic [3:0]       bcd_tens_q, bcd_tens_d;
    logic [3:0]       bcd_ones_q, bcd_ones_d;
    logic             ovf_q, ovf_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    logic [2:0] tens_lo;
    logic [3:0] ones_adj;
    logic [3:0] tens_nx;
    logic [3:0] ones_nx;
    logic [7:0] shreg_nx;
    logic       div_wrap;

    // One double-dabble step: add 3 to nibbles >= 5, then shift left by one.
    // The tens carry-out is dropped: it is only ever set for inputs >= 100,
    // and those results are discarded at commit anyway.
    always_comb begin
        tens_lo  = (tens_s_q >= 4'd5) ? 3'(tens_s_q + 4'd3) : tens_s_q[2:0];
        ones_adj = (ones_s_q >= 4'd5) ? (ones_s_q + 4'd3) : ones_s_q;
        {tens_nx, ones_nx, shreg_nx} = {tens_lo, ones_adj, shreg_q, 1'b0};
    end

    // Conversion FSM: start on a new value, run 8 steps, then commit the digits
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cap_d      = cap_q;
        tens_s_d   = tens_s_q;
        ones_s_d   = ones_s_q;
        iter_d     = iter_q;
        last_d     = last_q;
        have_d     = have_q;
        bcd_tens_d = bcd_tens_q;
        bcd_ones_d = bcd_ones_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if ((dd.value != last_q) || !have_q) begin
                    state_d  = ST_CONV;
                    shreg_d  = dd.value;
                    cap_d    = dd.value;
                    tens_s_d = 4'd0;
                    ones_s_d = 4'd0;
                    iter_d   = 3'd0;
                end
            end
            ST_CONV: begin
                shreg_d  = shreg_nx;
                tens_s_d = tens_nx;
                ones_s_d = ones_nx;
                iter_d   = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = ST_IDLE;
                    last_d  = cap_q;
                    have_d  = 1'b1;
                    if (cap_q >= 8'd100) begin
                        bcd_tens_d = 4'd0;
                        bcd_ones_d = 4'd0;
                        ovf_d      = 1'b1;
                    end else begin
                        bcd_tens_d = tens_nx;
                        bcd_ones_d = ones_nx;
                        ovf_d      = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Refresh divider: each digit slot lasts REFRESH_DIV cycles
    always_comb begin
        div_wrap = (div_q == DIV_W'(REFRESH_DIV - 1));
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        sel_d    = sel_q ^ div_wrap;
    end

    // Next seg/an from the current slot, the committed digits and blank
    always_comb begin
        an_d  = 2'b11;
        seg_d = SEG_OFF;
        if (!dd.blank) begin
            if (!sel_q) begin
                an_d  = 2'b10;
                seg_d = seg_pattern(bcd_ones_q);
            end else begin
                an_d  = 2'b01;
                seg_d = (bcd_tens_q == 4'd0) ? SEG_OFF : seg_pattern(bcd_tens_q);
            end
            if (ovf_q) begin
                seg_d = SEG_DASH;
            end
        end
    end

    // State registers; reset wins over everything, including a running conversion
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 8'd0;
            cap_q      <= 8'd0;
            tens_s_q   <= 4'd0;
            ones_s_q   <= 4'd0;
            iter_q     <= 3'd0;
            last_q     <= 8'd0;
            have_q     <= 1'b0;
            bcd_tens_q <= 4'd0;
            bcd_ones_q <= 4'd0;
            ovf_q      <= 1'b0;
            div_q      <= '0;
            sel_q      <= 1'b0;
            seg_q      <= SEG_OFF;
            an_q       <= 2'b11;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cap_q      <= cap_d;
            tens_s_q   <= tens_s_d;
            ones_s_q   <= ones_s_d;
            iter_q     <= iter_d;
            last_q     <= last_d;
            have_q     <= have_d;
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign dd.seg      = seg_q;
    assign dd.an       = an_q;
    assign dd.bcd_tens = bcd_tens_q;
    assign dd.bcd_ones = bcd_ones_q;
    assign dd.ovf      = ovf_q;
    assign dd.busy     = (state_q == ST_CONV);
    assign dd.state    = state_q;

endmodule

// File: tb/tb_two_digit_display_driver.sv
// Bench for two_digit_display_driver. Inputs change 1 time unit after each
// rising edge, and everything is checked on the falling edge. A cycle-level
// behavioural model predicts busy, the committed value and the display. It
// pushes the expected commit into exp_q when a conversion starts. A separate
// monitor pops exp_q whenever the DUT ends a conversion.
module tb_two_digit_display_driver;
    localparam int N = 4;

    logic clk;
    logic reset;
    two_digit_display_if dd_if ();

    two_digit_display_driver #(.REFRESH_DIV(N)) dut (
        .clk   (clk),
        .reset (reset),
        .dd    (dd_if.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [6:0] pat[10];

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected {ovf, tens, ones} of a commit of captured value v
    function automatic logic [8:0] commit_of(input int v);
        if (v >= 100) return 9'h100;
        return {1'b0, 4'(v / 10), 4'(v % 10)};
    endfunction

    // Expected {an, seg} for one slot given blank, slot select and committed value
    function automatic logic [8:0] disp_of(input logic bl, input logic s,
                                           input logic of, input int v);
        logic [6:0] sg;
        logic [1:0] a;
        if (bl) begin
            a = 2'b11; sg = 7'b1111111;
        end else if (!s) begin
            a = 2'b10; sg = of ? 7'b0111111 : pat[v % 10];
        end else begin
            a = 2'b01;
            sg = of ? 7'b0111111 : ((v / 10 == 0) ? 7'b1111111 : pat[v / 10]);
        end
        return {a, sg};
    endfunction

    // ---------------- behavioural model ----------------
    logic rst_prev   = 1'b1;
    logic blank_prev = 1'b0;
    int   val_prev   = 0;
    int   cyc = 0;
    logic m_sel = 1'b0;
    int   m_rem = 0;
    int   m_cap = 0;
    int   m_last = 0;
    logic m_have = 1'b0;
    logic m_ovf = 1'b0;
    int   m_val = 0;

    always @(negedge clk) begin
        if (rst_prev) begin
            chk("reset_disp", {dd_if.an, dd_if.seg}, 9'h1FF);
            chk("reset_busy", dd_if.busy, 0);
            chk("reset_bcd", {dd_if.ovf, dd_if.bcd_tens, dd_if.bcd_ones}, 0);
            cyc = 0; m_sel = 1'b0; m_rem = 0; m_have = 1'b0;
            m_ovf = 1'b0; m_val = 0;
            exp_q.delete();
        end else begin
            chk("display", {dd_if.an, dd_if.seg}, disp_of(blank_prev, m_sel, m_ovf, m_val));
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ovf  = (m_cap >= 100);
                    m_val  = (m_cap >= 100) ? 0 : m_cap;
                    m_last = m_cap;
                    m_have = 1'b1;
                end
            end else if ((val_prev != m_last) || !m_have) begin
                m_cap = val_prev;
                m_rem = 8;
                exp_q.push_back(commit_of(m_cap));
            end
            cyc++;
            m_sel = ((cyc / N) % 2) == 1;
            chk("busy", dd_if.busy, (m_rem > 0) ? 1 : 0);
            chk("state_dbg", dd_if.state, (m_rem > 0) ? 1 : 0);
        end
        rst_prev   = reset;
        blank_prev = dd_if.blank;
        val_prev   = dd_if.value;
    end

    // ---------------- commit monitor ----------------
    logic mon_rst_prev  = 1'b1;
    logic mon_busy_prev = 1'b0;
    int   mon_run = 0;

    always @(negedge clk) begin
        if (mon_rst_prev) begin
            mon_busy_prev = 1'b0;
            mon_run = 0;
        end else begin
            if (dd_if.busy) mon_run++;
            if (mon_busy_prev && !dd_if.busy) begin
                chk("busy_len", mon_run, 8);
                if (exp_q.size() == 0) begin
                    chk("commit_unexpected", {dd_if.ovf, dd_if.bcd_tens, dd_if.bcd_ones}, 9'h1FF);
                end else begin
                    chk("commit", {dd_if.ovf, dd_if.bcd_tens, dd_if.bcd_ones}, exp_q.pop_front());
                end
                mon_run = 0;
            end
            mon_busy_prev = dd_if.busy;
        end
        mon_rst_prev = reset;
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_busy(input int bound);
        int k;
        k = 0;
        while (!dd_if.busy && k < bound) begin
            tick(1);
            k++;
        end
        chk("busy_start", dd_if.busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dd_if.value = 8'd0;
        dd_if.blank = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(14);

        // Plain conversion and slot alternation
        dd_if.value = 8'd47;
        tick(20);

        // Overflow boundary and recovery
        dd_if.value = 8'd99;  tick(14);
        dd_if.value = 8'd100; tick(14);
        dd_if.value = 8'd0;   tick(14);

        // Value change while converting
        dd_if.value = 8'd25;
        wait_busy(20);
        tick(2);
        dd_if.value = 8'd52;
        tick(25);

        // Reset in the middle of a conversion
        dd_if.value = 8'd73;
        wait_busy(20);
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(20);

        // Blanking while conversions keep committing
        dd_if.value = 8'd38; tick(12);
        dd_if.blank = 1'b1;  tick(4);
        dd_if.value = 8'd61; tick(12);
        dd_if.blank = 1'b0;  tick(12);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0)
                dd_if.value = 8'($urandom_range(95, 105));
            else
                dd_if.value = 8'($urandom_range(0, 255));
            dd_if.blank = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            tick($urandom_range(1, 14));
        end

        dd_if.blank = 1'b0;
        tick(30);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
